// File: rtl/drc_axi_pusher_rr.sv
// AXI4 write-burst master: drains per-path descriptor/data FIFOs into one AW/W/B channel with round-robin arbitration.
// Optional BRESP error capture is enabled by defining DRC_AXI_PUSHER_BRESP_ERR_EN.
module drc_axi_pusher_rr #(
    parameter int p_paths      = 2,
    parameter int p_data_width = 128,
    parameter int p_addr_width = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [p_paths*(8+p_addr_width)-1:0]   paths_burst_in,
    input  logic [p_paths-1:0]                    paths_burst_empty,
    output logic [p_paths-1:0]                    paths_burst_rd,
    input  logic [p_paths*p_data_width-1:0]       paths_data_in,
    input  logic [p_paths-1:0]                    paths_data_empty,
    output logic [p_paths-1:0]                    paths_data_rd,
    output logic [p_addr_width-1:0]               awaddr,
    output logic [7:0]                            awlen,
    output logic [2:0]                            awsize,
    output logic [1:0]                            awburst,
    output logic [3:0]                            awcache,
    output logic [2:0]                            awproto,
    output logic                                  awvalid,
    input  logic                                  awready,
    output logic [p_data_width-1:0]               wdata,
    output logic [p_data_width/8-1:0]             wstrb,
    output logic                                  wlast,
    output logic                                  wvalid,
    input  logic                                  wready,
    input  logic [1:0]                            bresp,
    input  logic                                  bvalid,
    output logic                                  bready,
    output logic                                  o_busy,
    output logic [p_paths-1:0]                    o_grant,
    output logic [p_paths-1:0]                    o_err_flags,
    output logic [1:0]                            o_err_resp,
    output logic [p_addr_width-1:0]               o_err_addr,
    input  logic                                  i_err_clr
);
    localparam int p_dw = 8 + p_addr_width;
    localparam int idx_w = (p_paths > 1) ? $clog2(p_paths) : 1;
    localparam logic [2:0] c_awsize = 3'($clog2(p_data_width / 8));

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t            state;
    logic [idx_w-1:0]  last;
    logic [idx_w-1:0]  gsel;
    logic [idx_w-1:0]  pick;
    logic [idx_w-1:0]  cand;
    logic [p_paths-1:0] pick_oh;
    logic              found;
    logic [7:0]        beat_cnt;
    logic [p_dw-1:0]   desc;
    logic              w_fire;

    function automatic logic [idx_w-1:0] wrap_inc(input logic [idx_w-1:0] v);
        if (int'(v) >= p_paths - 1) return '0;
        return v + 1'b1;
    endfunction

    // Search starts one past the last served path so every pending path is reached within p_paths grants.
    always_comb begin
        found   = 1'b0;
        pick    = '0;
        pick_oh = '0;
        cand    = wrap_inc(last);
        for (int i = 0; i < p_paths; i++) begin
            if (!found && !paths_burst_empty[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = wrap_inc(cand);
        end
        pick_oh[pick] = 1'b1;
    end

    assign desc  = paths_burst_in[int'(pick)*p_dw +: p_dw];
    assign wdata = paths_data_in[int'(gsel)*p_data_width +: p_data_width];

    // NOTE: pops and wvalid are combinational, so they are masked by i_rst to stop any pop while the state register is still being reset.
    assign wvalid         = !i_rst && (state == DATA) && !paths_data_empty[gsel];
    assign wlast          = !i_rst && (state == DATA) && (beat_cnt == 8'd0);
    assign w_fire         = wvalid && wready;
    assign paths_data_rd  = w_fire ? o_grant : '0;
    assign paths_burst_rd = (!i_rst && (state == IDLE) && found) ? pick_oh : '0;

    assign o_busy  = (state != IDLE);
    assign awsize  = c_awsize;
    assign awburst = 2'b01;
    assign awcache = 4'b0011;
    assign awproto = 3'b000;
    assign wstrb   = '1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            last     <= idx_w'(p_paths - 1);
            gsel     <= '0;
            o_grant  <= '0;
            awaddr   <= '0;
            awlen    <= '0;
            beat_cnt <= '0;
            awvalid  <= 1'b0;
            bready   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    gsel     <= pick;
                    last     <= pick;
                    o_grant  <= pick_oh;
                    awaddr   <= desc[8 +: p_addr_width];
                    awlen    <= desc[7:0] - 8'd1;
                    beat_cnt <= desc[7:0] - 8'd1;
                    awvalid  <= 1'b1;
                    state    <= ADDR;
                end
                ADDR: if (awready) begin
                    awvalid <= 1'b0;
                    state   <= DATA;
                end
                DATA: if (w_fire) begin
                    beat_cnt <= beat_cnt - 8'd1;
                    if (beat_cnt == 8'd0) begin
                        bready <= 1'b1;
                        state  <= RESP;
                    end
                end
                RESP: if (bvalid) begin
                    bready  <= 1'b0;
                    o_grant <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DRC_AXI_PUSHER_BRESP_ERR_EN
    // Only the first error after reset/clear is recorded; later ones just add their path flag.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_err_clr) begin
            o_err_flags <= '0;
            o_err_resp  <= 2'b00;
            o_err_addr  <= '0;
        end else if ((state == RESP) && bvalid && (bresp != 2'b00)) begin
            o_err_flags <= o_err_flags | o_grant;
            if (o_err_flags == '0) begin
                o_err_resp <= bresp;
                o_err_addr <= awaddr;
            end
        end
    end
`else
    logic unused_err;
    assign unused_err  = ^{bresp, i_err_clr};
    assign o_err_flags = '0;
    assign o_err_resp  = 2'b00;
    assign o_err_addr  = '0;
`endif

endmodule

// File: tb/tb_drc_axi_pusher_rr.sv
// Directed bench for drc_axi_pusher_rr: FIFO models feed two paths, a monitor logs AW/W traffic, assertions check it.
module tb_drc_axi_pusher_rr;
    localparam int NP  = 2;
    localparam int DW  = 256;
    localparam int AWD = 32;
    localparam int DD  = 8 + AWD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             i_rst = 1'b1;
    logic [NP*DD-1:0] paths_burst_in = '0;
    logic [NP-1:0]    paths_burst_empty = '1;
    logic [NP-1:0]    paths_burst_rd;
    logic [NP*DW-1:0] paths_data_in = '0;
    logic [NP-1:0]    paths_data_empty = '1;
    logic [NP-1:0]    paths_data_rd;
    logic [AWD-1:0]   awaddr;
    logic [7:0]       awlen;
    logic [2:0]       awsize;
    logic [1:0]       awburst;
    logic [3:0]       awcache;
    logic [2:0]       awproto;
    logic             awvalid;
    logic             awready = 1'b1;
    logic [DW-1:0]    wdata;
    logic [DW/8-1:0]  wstrb;
    logic             wlast;
    logic             wvalid;
    logic             wready = 1'b1;
    logic [1:0]       bresp = 2'b00;
    logic             bvalid = 1'b0;
    logic             bready;
    logic             o_busy;
    logic [NP-1:0]    o_grant;
    logic [NP-1:0]    o_err_flags;
    logic [1:0]       o_err_resp;
    logic [AWD-1:0]   o_err_addr;
    logic             i_err_clr = 1'b0;

    drc_axi_pusher_rr #(.p_paths(NP), .p_data_width(DW), .p_addr_width(AWD)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .paths_burst_in(paths_burst_in), .paths_burst_empty(paths_burst_empty), .paths_burst_rd(paths_burst_rd),
        .paths_data_in(paths_data_in), .paths_data_empty(paths_data_empty), .paths_data_rd(paths_data_rd),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awcache(awcache),
        .awproto(awproto), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .o_busy(o_busy), .o_grant(o_grant), .o_err_flags(o_err_flags),
        .o_err_resp(o_err_resp), .o_err_addr(o_err_addr), .i_err_clr(i_err_clr)
    );

    int checks = 0;
    int failures = 0;

    // FIFO models and stimulus knobs
    logic [DD-1:0] bq[NP][$];
    logic [DW-1:0] dq[NP][$];
    int            pseq[NP];
    int            gap_len = 0;
    int            gap_cnt = 0;
    logic          forced_now = 1'b0;
    logic          wr_toggle = 1'b0;
    logic [1:0]    resp_val = 2'b00;

    // Monitor logs
    int            cyc = 0;
    logic [AWD-1:0] aw_addr_q[$];
    logic [7:0]    aw_len_q[$];
    logic [NP-1:0] aw_gnt_q[$];
    logic [DW-1:0] w_data_q[$];
    int            bpop[NP];
    int            dpop[NP];
    int            w_n, wlast_n, wlast_at;
    int            grant_cycle, aw_cycle, first_w_cycle;
    int            stab_err, aw_stall, gap_viol, rd_err, rst_pop;
    logic          aw_pend = 1'b0;
    logic [AWD-1:0] pa;
    logic [7:0]    pl;

    function automatic logic [DW-1:0] word(input int p, input int n);
        return {8{8'(p), 24'(n)}};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_desc(input int p, input logic [AWD-1:0] addr, input logic [7:0] cnt);
        bq[p].push_back({addr, cnt});
    endtask

    task automatic push_data(input int p, input int k);
        for (int i = 0; i < k; i++) begin
            dq[p].push_back(word(p, pseq[p]));
            pseq[p]++;
        end
    endtask

    task automatic clear_logs();
        aw_addr_q.delete(); aw_len_q.delete(); aw_gnt_q.delete(); w_data_q.delete();
        for (int p = 0; p < NP; p++) begin bpop[p] = 0; dpop[p] = 0; end
        w_n = 0; wlast_n = 0; wlast_at = -1;
        grant_cycle = -1; aw_cycle = -1; first_w_cycle = -1;
        stab_err = 0; aw_stall = 0; gap_viol = 0; rd_err = 0; rst_pop = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bq[0].size() != 0 || bq[1].size() != 0 || o_busy) && n < budget);
        check({tag, "_timeout"}, (n < budget), 1'b1);
    endtask

    task automatic check_beats(input string tag, input int p, input int start, input int n);
        check({tag, "_beats"}, w_data_q.size(), n);
        for (int i = 0; i < w_data_q.size(); i++)
            check({tag, "_wdata"}, w_data_q[i], word(p, start + i));
    endtask

    // Drive FIFO heads after the falling edge, sample the handshakes just before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                paths_burst_empty[p]    = (bq[p].size() == 0);
                paths_burst_in[p*DD +: DD] = (bq[p].size() != 0) ? bq[p][0] : '0;
                paths_data_empty[p]     = (dq[p].size() == 0);
                paths_data_in[p*DW +: DW] = (dq[p].size() != 0) ? dq[p][0] : '0;
            end
            forced_now = (gap_cnt > 0);
            if (forced_now) begin
                paths_data_empty = '1;
                gap_cnt--;
            end
            wready = wr_toggle ? (cyc % 2 == 0) : 1'b1;
            bvalid = bready;
            bresp  = resp_val;
            #3;
            cyc++;
            if ($countones(paths_burst_rd) > 1) rd_err++;
            if (paths_data_rd !== ((wvalid && wready) ? o_grant : '0)) rd_err++;
            if (i_rst && ((paths_burst_rd | paths_data_rd) != '0)) rst_pop++;
            for (int p = 0; p < NP; p++) begin
                if (paths_burst_rd[p]) begin
                    if (bq[p].size() == 0) rd_err++; else void'(bq[p].pop_front());
                    bpop[p]++;
                    if (grant_cycle < 0) grant_cycle = cyc;
                end
                if (paths_data_rd[p]) begin
                    if (dq[p].size() == 0) rd_err++; else void'(dq[p].pop_front());
                    dpop[p]++;
                end
            end
            if (awvalid) begin
                if (aw_pend && (awaddr !== pa || awlen !== pl)) stab_err++;
                if (!awready) aw_stall++;
                pa = awaddr;
                pl = awlen;
                aw_pend = !awready;
                if (awready) begin
                    aw_addr_q.push_back(awaddr);
                    aw_len_q.push_back(awlen);
                    aw_gnt_q.push_back(o_grant);
                    aw_cycle = cyc;
                    gap_cnt = gap_len;
                end
            end else begin
                aw_pend = 1'b0;
            end
            if (wvalid && wready) begin
                w_n++;
                w_data_q.push_back(wdata);
                if (wlast) begin wlast_n++; wlast_at = w_n; end
                if (first_w_cycle < 0) first_w_cycle = cyc;
            end
            if (forced_now && (wvalid || paths_data_rd != '0)) gap_viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1;
        logic [1:0]     exp_resp;
        logic [AWD-1:0] exp_eaddr;
        logic [NP-1:0]  exp_flags;
        for (int p = 0; p < NP; p++) pseq[p] = 0;
        clear_logs();

        // Reset values
        i_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_awlen", awlen, 8'h0);
        check("rst_burst_rd", paths_burst_rd, 2'b00);
        check("rst_data_rd", paths_data_rd, 2'b00);
        check("rst_grant", o_grant, 2'b00);
        check("rst_busy", o_busy, 1'b0);
        check("rst_err_flags", o_err_flags, 2'b00);
        check("rst_err_resp", o_err_resp, 2'b00);
        check("rst_err_addr", o_err_addr, 32'h0);
        check("const_awsize", awsize, 3'd5);
        check("const_awburst", awburst, 2'b01);
        check("const_awcache", awcache, 4'b0011);
        check("const_awproto", awproto, 3'b000);
        check("const_wstrb", wstrb, 32'hFFFF_FFFF);
        i_rst = 1'b0;
        @(negedge clk);

        // Single 4-beat burst on path 0
        clear_logs();
        s0 = pseq[0];
        push_data(0, 4);
        push_desc(0, 32'h1000, 8'd4);
        wait_done("A", 50);
        check("A_aw_count", aw_addr_q.size(), 1);
        check("A_awaddr", aw_addr_q[0], 32'h1000);
        check("A_awlen", aw_len_q[0], 8'd3);
        check("A_aw_latency", aw_cycle - grant_cycle, 1);
        check("A_w_latency", first_w_cycle - aw_cycle, 1);
        check_beats("A", 0, s0, 4);
        check("A_wlast_n", wlast_n, 1);
        check("A_wlast_at", wlast_at, 4);
        check("A_burst_pops", bpop[0], 1);
        check("A_data_pops", dpop[0], 4);
        check("A_busy", o_busy, 1'b0);
        check("A_grant", o_grant, 2'b00);

        // Path 1, 8 beats, data withheld 5 cycles after the AW handshake
        clear_logs();
        s1 = pseq[1];
        gap_len = 5;
        push_data(1, 8);
        push_desc(1, 32'h3000, 8'd8);
        wait_done("C", 60);
        gap_len = 0;
        check("C_awaddr", aw_addr_q[0], 32'h3000);
        check("C_awlen", aw_len_q[0], 8'd7);
        check("C_gap_viol", gap_viol, 0);
        check("C_resume", first_w_cycle - aw_cycle, 6);
        check_beats("C", 1, s1, 8);
        check("C_wlast_n", wlast_n, 1);
        check("C_wlast_at", wlast_at, 8);
        check("C_data_pops", dpop[1], 8);

        // Round robin with both paths loaded together
        clear_logs();
        s0 = pseq[0];
        s1 = pseq[1];
        for (int i = 0; i < 3; i++) begin
            push_desc(0, 32'h100 * (i + 1), 8'd1);
            push_desc(1, 32'h1100 + 32'h100 * i, 8'd1);
        end
        push_data(0, 3);
        push_data(1, 3);
        wait_done("B", 100);
        check("B_aw_count", aw_addr_q.size(), 6);
        for (int i = 0; i < aw_addr_q.size(); i++) begin
            check("B_grant", aw_gnt_q[i], (i % 2 == 0) ? 2'b01 : 2'b10);
            check("B_awaddr", aw_addr_q[i], ((i % 2 == 0) ? 32'h100 : 32'h1100) + 32'h100 * (i / 2));
        end
        check("B_beats", w_data_q.size(), 6);
        for (int i = 0; i < w_data_q.size(); i++)
            check("B_wdata", w_data_q[i], word(i % 2, ((i % 2 == 0) ? s0 : s1) + i / 2));

        // Count 0 means 256 beats
        clear_logs();
        s0 = pseq[0];
        push_data(0, 256);
        push_desc(0, 32'h4000, 8'd0);
        wait_done("D", 400);
        check("D_awlen", aw_len_q[0], 8'd255);
        check("D_awsize", awsize, 3'd5);
        check_beats("D", 0, s0, 256);
        check("D_wlast_n", wlast_n, 1);
        check("D_wlast_at", wlast_at, 256);

        // awready held low 10 cycles, wready toggling
        clear_logs();
        s1 = pseq[1];
        awready = 1'b0;
        wr_toggle = 1'b1;
        push_data(1, 6);
        push_desc(1, 32'h5000, 8'd6);
        repeat (11) @(negedge clk);
        awready = 1'b1;
        wait_done("E", 80);
        wr_toggle = 1'b0;
        check("E_aw_stall", aw_stall, 10);
        check("E_stable", stab_err, 0);
        check("E_awaddr", aw_addr_q[0], 32'h5000);
        check_beats("E", 1, s1, 6);
        check("E_pops_eq_hs", dpop[1], w_n);
        check("E_wlast_at", wlast_at, 6);

        // BRESP error capture
`ifdef DRC_AXI_PUSHER_BRESP_ERR_EN
        exp_flags = 2'b01; exp_resp = 2'b10; exp_eaddr = 32'h2000;
`else
        exp_flags = 2'b00; exp_resp = 2'b00; exp_eaddr = 32'h0;
`endif
        clear_logs();
        resp_val = 2'b10;
        push_data(0, 2);
        push_desc(0, 32'h2000, 8'd2);
        wait_done("F1", 50);
        check("F1_flags", o_err_flags, exp_flags);
        check("F1_resp", o_err_resp, exp_resp);
        check("F1_addr", o_err_addr, exp_eaddr);
        push_data(1, 1);
        push_desc(1, 32'h6000, 8'd1);
        wait_done("F2", 50);
`ifdef DRC_AXI_PUSHER_BRESP_ERR_EN
        exp_flags = 2'b11;
`endif
        check("F2_flags", o_err_flags, exp_flags);
        check("F2_resp", o_err_resp, exp_resp);
        check("F2_addr", o_err_addr, exp_eaddr);
        check("F_bursts", aw_addr_q.size(), 2);
        resp_val = 2'b00;
        i_err_clr = 1'b1;
        @(negedge clk);
        i_err_clr = 1'b0;
        @(negedge clk);
        check("F3_flags", o_err_flags, 2'b00);
        check("F3_resp", o_err_resp, 2'b00);
        check("F3_addr", o_err_addr, 32'h0);

        // Reset in the middle of a stalled burst
        clear_logs();
        push_data(0, 2);
        push_desc(0, 32'h8000, 8'd4);
        repeat (8) @(negedge clk);
        check("G_busy_before", o_busy, 1'b1);
        check("G_stalled", wvalid, 1'b0);
        i_rst = 1'b1;
        push_data(0, 2);
        @(negedge clk);
        i_rst = 1'b0;
        repeat (3) @(negedge clk);
        check("G_rst_pops", rst_pop, 0);
        check("G_data_pops", dpop[0], 2);
        check("G_burst_pops", bpop[0], 1);
        check("G_beats", w_n, 2);
        check("G_no_wlast", wlast_n, 0);
        check("G_busy", o_busy, 1'b0);
        check("G_grant", o_grant, 2'b00);
        check("G_awvalid", awvalid, 1'b0);
        check("G_rd_err", rd_err, 0);
        dq[0].delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
